// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared UART receive definitions. Holds the receive FSM state
//                encoding, the counter width constants and a helper that
//                turns the raw Prescale input into the effective ratio.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Counter widths
    localparam int c_EDGE_W = 6;
    localparam int c_BIT_W  = 4;

    // Receive FSM state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Index of the last data bit within a frame (start bit is index 0)
    localparam logic [c_BIT_W-1:0] c_LAST_DATA_BIT = 4'd8;

    // Ratios below 4 leave too few oversamples per bit; clamp them up.
    function automatic logic [c_EDGE_W-1:0] eff_prescale(input logic [c_EDGE_W-1:0] p);
        return (p < 6'd4) ? 6'd4 : p;
    endfunction

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/rx_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fsm_if
//  Description : Connection bundle between the UART receive controller and
//                its sampler / check / deserialiser datapath.
//                master : the controller (rx_fsm)
//                slave  : the datapath side (line, config, check results)
//  Ports       : RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err
//                  (slave -> master)
//                dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
//                par_chk_en, stp_chk_en, data_valid (master -> slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_fsm_if;
    import uart_rx_pkg::*;

    logic                RX_IN;
    logic                PAR_EN;
    logic [c_EDGE_W-1:0] Prescale;
    logic                strt_glitch;
    logic                par_err;
    logic                stp_err;

    logic                dat_samp_en;
    logic [c_EDGE_W-1:0] edge_cnt;
    logic [c_BIT_W-1:0]  bit_cnt;
    logic                strt_chk_en;
    logic                deser_en;
    logic                par_chk_en;
    logic                stp_chk_en;
    logic                data_valid;

    modport master (
        input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        output dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
               par_chk_en, stp_chk_en, data_valid
    );

    modport slave (
        output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        input  dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
               par_chk_en, stp_chk_en, data_valid
    );

endinterface : rx_fsm_if
`default_nettype wire

// File: rtl/rx_fsm_edge_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_bit_counter
//  Description : Oversample edge counter and frame bit counter. While enabled
//                the edge counter runs 0..P-1 and wraps, bumping the bit
//                counter on each wrap. When disabled both are cleared.
//  Ports       : CLK, RST (async active-low), i_en, i_prescale (effective P),
//                o_edge_cnt, o_bit_cnt, o_eob (edge_cnt == P-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  wire logic                CLK,
    input  wire logic                RST,
    input  wire logic                i_en,
    input  wire logic [c_EDGE_W-1:0] i_prescale,
    output logic      [c_EDGE_W-1:0] o_edge_cnt,
    output logic      [c_BIT_W-1:0]  o_bit_cnt,
    output logic                     o_eob
);

    logic [c_EDGE_W-1:0] r_edge_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic                w_eob;

    assign w_eob = (r_edge_cnt == (i_prescale - 6'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!i_en) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_eob) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_eob      = w_eob;

endmodule : edge_bit_counter
`default_nettype wire

// File: rtl/rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fsm
//  Description : UART receive controller. Tracks a frame through
//                IDLE -> START -> DATA -> [PARITY] -> STOP, steers the
//                per-stage check enables and pulses data_valid for a frame
//                received without start, parity or stop error.
//  Ports       : CLK  - oversampling clock
//                RST  - asynchronous active-low reset
//                bus  - rx_fsm_if.master (line, config, check results in;
//                       counters, enables, data_valid out)
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_fsm
    import uart_rx_pkg::*;
(
    input  wire logic CLK,
    input  wire logic RST,
    rx_fsm_if.master  bus
);

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic                r_par_en;
    logic [c_EDGE_W-1:0] r_prescale;
    logic                r_frame_err;

    logic                w_start_entry;
    logic                w_cnt_en;
    logic                w_eob;
    logic [c_EDGE_W-1:0] w_edge_cnt;
    logic [c_BIT_W-1:0]  w_bit_cnt;

    assign w_start_entry = (r_state == c_ST_IDLE) && (w_next == c_ST_START);

    // Counters run only while the frame continues into the next cycle, so
    // leaving a frame returns them straight to 0 for the following IDLE.
    assign w_cnt_en = (r_state != c_ST_IDLE) && (w_next != c_ST_IDLE);

    edge_bit_counter u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .i_en       (w_cnt_en),
        .i_prescale (r_prescale),
        .o_edge_cnt (w_edge_cnt),
        .o_bit_cnt  (w_bit_cnt),
        .o_eob      (w_eob)
    );

    // ---------------- State register ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame configuration and sticky error flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en    <= 1'b0;
            r_prescale  <= 6'd4;
            r_frame_err <= 1'b0;
        end else if (w_start_entry) begin
            r_par_en    <= bus.PAR_EN;
            r_prescale  <= eff_prescale(bus.Prescale);
            r_frame_err <= 1'b0;
        end else if ((r_state == c_ST_PARITY) && w_eob && bus.par_err) begin
            r_frame_err <= 1'b1;
        end
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!bus.RX_IN) w_next = c_ST_START;
            end
            c_ST_START: begin
                if (w_eob) w_next = bus.strt_glitch ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_eob && (w_bit_cnt == c_LAST_DATA_BIT))
                    w_next = r_par_en ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: begin
                if (w_eob) w_next = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (w_eob) w_next = c_ST_IDLE;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    // ---------------- Output logic ----------------
    always_comb begin
        bus.dat_samp_en = 1'b0;
        bus.strt_chk_en = 1'b0;
        bus.deser_en    = 1'b0;
        bus.par_chk_en  = 1'b0;
        bus.stp_chk_en  = 1'b0;
        bus.data_valid  = 1'b0;
        case (r_state)
            c_ST_START: begin
                bus.dat_samp_en = 1'b1;
                bus.strt_chk_en = 1'b1;
            end
            c_ST_DATA: begin
                bus.dat_samp_en = 1'b1;
                bus.deser_en    = 1'b1;
            end
            c_ST_PARITY: begin
                bus.dat_samp_en = 1'b1;
                bus.par_chk_en  = 1'b1;
            end
            c_ST_STOP: begin
                bus.dat_samp_en = 1'b1;
                bus.stp_chk_en  = 1'b1;
                // Stop result is only valid late in the bit, so qualify at EOB
                bus.data_valid  = w_eob && !bus.stp_err && !r_frame_err;
            end
            default: ;
        endcase
    end

    assign bus.edge_cnt = w_edge_cnt;
    assign bus.bit_cnt  = w_bit_cnt;

endmodule : rx_fsm
`default_nettype wire

// File: tb/tb_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_fsm
//  Description : Directed self-checking bench for rx_fsm. Frames are driven
//                cycle by cycle; per-frame observations are compared against
//                hand-computed frame timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_fsm;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    rx_fsm_if bus ();

    rx_fsm dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Per-frame observations
    int dv_cnt, dv_cyc, stp_first, stp_last, stp_cnt, max_bit;
    int idle_first, deser_seen, par_seen, cnt_err;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drives one frame starting with RX_IN low in an IDLE cycle, then observes
    // ncyc frame cycles (cycle 1 = first START cycle). Returns at the sample
    // point of cycle ncyc+1.
    task automatic run_frame(input logic [5:0] psc, input bit par, input logic [7:0] data,
                             input bit glitch, input bit perr, input bit serr,
                             input bit stop_low, input bit scramble, input int ncyc);
        int pe, flen, nbits, bi, exp_e, exp_b, exp_s;
        logic line;
        pe    = (psc < 4) ? 4 : int'(psc);
        nbits = par ? 11 : 10;
        flen  = glitch ? pe : nbits * pe;
        dv_cnt = 0; dv_cyc = 0; stp_first = 0; stp_last = 0; stp_cnt = 0;
        max_bit = 0; idle_first = 0; deser_seen = 0; par_seen = 0; cnt_err = 0;
        bus.Prescale    = psc;
        bus.PAR_EN      = par;
        bus.strt_glitch = glitch;
        bus.par_err     = perr;
        bus.stp_err     = serr;
        bus.RX_IN       = 1'b0;
        tick();
        for (int c = 1; c <= ncyc; c++) begin
            if (bus.data_valid === 1'b1) begin dv_cnt++; dv_cyc = c; end
            if (bus.stp_chk_en === 1'b1) begin
                if (stp_first == 0) stp_first = c;
                stp_last = c;
                stp_cnt++;
            end
            if (bus.deser_en === 1'b1)   deser_seen = 1;
            if (bus.par_chk_en === 1'b1) par_seen = 1;
            if (int'(bus.bit_cnt) > max_bit) max_bit = int'(bus.bit_cnt);
            if (idle_first == 0 && bus.dat_samp_en === 1'b0) idle_first = c;
            if (c <= flen) begin
                exp_e = (c - 1) % pe; exp_b = (c - 1) / pe; exp_s = 1;
            end else begin
                exp_e = 0; exp_b = 0; exp_s = 0;
            end
            if (bus.edge_cnt !== 6'(exp_e) || bus.bit_cnt !== 4'(exp_b) ||
                bus.dat_samp_en !== 1'(exp_s))
                cnt_err++;
            // Line level for this cycle
            bi = (c - 1) / pe;
            if (c > flen)                line = 1'b1;
            else if (bi == 0)            line = glitch;
            else if (bi <= 8)            line = data[bi-1];
            else if (bi == nbits - 1)    line = ~stop_low;
            else                         line = ^data;
            bus.RX_IN = line;
            if (scramble && c == 1) begin
                bus.Prescale = 6'd5;
                bus.PAR_EN   = ~par;
            end
            tick();
        end
        bus.Prescale = psc;
        bus.PAR_EN   = par;
    endtask

    initial begin
        bus.RX_IN       = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.Prescale    = 6'd8;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;

        // ---- Reset state ----
        #12;
        chk("rst_samp_en", bus.dat_samp_en, 0);
        chk("rst_edge",    bus.edge_cnt, 0);
        chk("rst_bit",     bus.bit_cnt, 0);
        chk("rst_enables", {bus.strt_chk_en, bus.deser_en, bus.par_chk_en, bus.stp_chk_en}, 0);
        chk("rst_dv",      bus.data_valid, 0);
        @(negedge CLK);
        RST = 1'b1;
        tick();
        chk("idle_samp_en", bus.dat_samp_en, 0);

        // ---- P=8, no parity, 0xA5, clean stop ----
        run_frame(6'd8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 82);
        chk("p8_dv_cnt",    dv_cnt, 1);
        chk("p8_dv_cyc",    dv_cyc, 80);
        chk("p8_stp_first", stp_first, 73);
        chk("p8_stp_last",  stp_last, 80);
        chk("p8_stp_cnt",   stp_cnt, 8);
        chk("p8_par_seen",  par_seen, 0);
        chk("p8_max_bit",   max_bit, 9);
        chk("p8_idle",      idle_first, 81);
        chk("p8_cnt_err",   cnt_err, 0);

        // ---- P=16, parity, config changed mid-frame (must be ignored) ----
        run_frame(6'd16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 178);
        chk("p16_max_bit",  max_bit, 10);
        chk("p16_dv_cnt",   dv_cnt, 1);
        chk("p16_dv_cyc",   dv_cyc, 176);
        chk("p16_par_seen", par_seen, 1);
        chk("p16_cnt_err",  cnt_err, 0);

        // ---- Start glitch ----
        run_frame(6'd8, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        chk("gl_idle",   idle_first, 9);
        chk("gl_deser",  deser_seen, 0);
        chk("gl_dv_cnt", dv_cnt, 0);
        chk("gl_cnt_err", cnt_err, 0);

        // ---- Parity error ----
        run_frame(6'd8, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 90);
        chk("pe_stp_first", stp_first, 81);
        chk("pe_stp_last",  stp_last, 88);
        chk("pe_dv_cnt",    dv_cnt, 0);
        chk("pe_cnt_err",   cnt_err, 0);

        // ---- Stop error, next frame one cycle later ----
        run_frame(6'd8, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 80);
        chk("se_dv_cnt",   dv_cnt, 0);
        chk("se_stp_cnt",  stp_cnt, 8);
        run_frame(6'd8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 82);
        chk("se2_dv_cnt",  dv_cnt, 1);
        chk("se2_dv_cyc",  dv_cyc, 80);
        chk("se2_cnt_err", cnt_err, 0);

        // ---- Prescale below 4 clamps to 4; low line in STOP is ignored ----
        run_frame(6'd2, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 44);
        chk("p2_dv_cyc",   dv_cyc, 40);
        chk("p2_dv_cnt",   dv_cnt, 1);
        chk("p2_idle",     idle_first, 41);
        chk("p2_cnt_err",  cnt_err, 0);

        // ---- Reset mid-DATA at bit_cnt=4 ----
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        tick();
        bus.RX_IN    = 1'b1;
        for (int c = 1; c < 35; c++) tick();
        chk("mr_bit_pre",   bus.bit_cnt, 4);
        chk("mr_deser_pre", bus.deser_en, 1);
        #2 RST = 1'b0;
        #1;
        chk("mr_samp_en", bus.dat_samp_en, 0);
        chk("mr_deser",   bus.deser_en, 0);
        chk("mr_counts",  {bus.edge_cnt, bus.bit_cnt}, 0);
        chk("mr_dv",      bus.data_valid, 0);
        @(negedge CLK);
        RST = 1'b1;
        run_frame(6'd8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 82);
        chk("mr2_dv_cnt",  dv_cnt, 1);
        chk("mr2_dv_cyc",  dv_cyc, 80);
        chk("mr2_cnt_err", cnt_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rx_fsm
`default_nettype wire
